// File: rtl/fflopd_pkg.sv
// Shared definitions for the fflopd_pipe register pipeline.
//
// clog2_cnt(depth) gives the width of the occupancy counter. The counter
// must hold every value from 0 to depth, and it is never narrower than 1 bit.
//
// Each module that uses this package defines SCAN_LEN = WIDTH*DEPTH
// locally. SCAN_LEN is the number of data bits on the serial scan chain.
package fflopd_pkg;

  function automatic int clog2_cnt(input int depth);
    int w;
    w = 1;
    for (int i = 0; i < 32; i++)
      if ((1 << w) < depth + 1) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/fflopd_stage.sv
// One pipeline stage: a WIDTH-bit data register and its valid bit.
//
// Ports
//   CK, RN        clock (rising edge) and async active-low reset
//   clr_i         synchronous clear to RESET_VAL / invalid
//   scan_en_i     shift the data register by one bit (valid holds)
//   scan_in_i     serial bit entering data bit 0
//   adv_en_i      load d_i/v_i (caller masks this with scan)
//   d_i, v_i      parallel data/valid from the previous stage
//   q_o, v_o      registered data/valid
// Priority inside the stage is clear > scan > advance > hold.
module fflopd_stage #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             clr_i,
  input  logic             scan_en_i,
  input  logic             scan_in_i,
  input  logic             adv_en_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             v_i,
  output logic [WIDTH-1:0] q_o,
  output logic             v_o
);

  logic [WIDTH-1:0] data_q, data_d, scan_nxt;
  logic             vld_q, vld_d;

  // The scan chain enters at bit 0 and moves toward bit WIDTH-1.
  if (WIDTH == 1) begin : g_scan1
    assign scan_nxt = scan_in_i;
  end else begin : g_scanw
    assign scan_nxt = {data_q[WIDTH-2:0], scan_in_i};
  end

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_i) begin
      data_d = RESET_VAL;
      vld_d  = 1'b0;
    end else if (scan_en_i) begin
      data_d = scan_nxt;
    end else if (adv_en_i) begin
      data_d = d_i;
      vld_d  = v_i;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o = data_q;
  assign v_o = vld_q;

endmodule

// File: rtl/fflopd_pipe.sv
// A WIDTH-bit, DEPTH-stage register pipeline. It supports stall,
// synchronous clear, scan shift and an occupancy counter.
//
// Ports
//   CK, RN   clock (rising edge) and async active-low reset
//   EN       advance all stages (0 = stall)
//   CLR      synchronous clear, which has the highest priority
//   SE, SI   scan enable and serial input (the chain is SI -> stage0[0] ..
//            stage(DEPTH-1)[WIDTH-1] -> SO)
//   D, VI    data and valid into stage 0
//   Q, VO    data and valid of the last stage
//   SO       last stage data bit WIDTH-1
//   CNT      number of valid stages, kept as an up/down counter
// All outputs come directly from flops.
module fflopd_pipe
  import fflopd_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        CK,
  input  logic                        RN,
  input  logic                        EN,
  input  logic                        CLR,
  input  logic                        SE,
  input  logic                        SI,
  input  logic [WIDTH-1:0]            D,
  input  logic                        VI,
  output logic [WIDTH-1:0]            Q,
  output logic                        VO,
  output logic                        SO,
  output logic [clog2_cnt(DEPTH)-1:0] CNT
);

  localparam int CW       = clog2_cnt(DEPTH);
  localparam int SCAN_LEN = WIDTH * DEPTH;

  if (DEPTH < 1) begin : g_bad_depth
    $error("fflopd_pipe: DEPTH must be at least 1");
  end
  if (SCAN_LEN < 1) begin : g_bad_width
    $error("fflopd_pipe: WIDTH must be at least 1");
  end

  logic [DEPTH-1:0][WIDTH-1:0] stg_q;
  logic [DEPTH-1:0]            stg_v;
  logic                        adv;
  logic [CW-1:0]               cnt_q, cnt_d;

  // Scan overrides the advance, so a stage never sees both operations at once.
  assign adv = EN & ~SE;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    logic [WIDTH-1:0] din;
    logic             vin, sin;
    if (k == 0) begin : g_head
      assign din = D;
      assign vin = VI;
      assign sin = SI;
    end else begin : g_body
      assign din = stg_q[k-1];
      assign vin = stg_v[k-1];
      assign sin = stg_q[k-1][WIDTH-1];
    end
    fflopd_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stg (
      .CK       (CK),
      .RN       (RN),
      .clr_i    (CLR),
      .scan_en_i(SE),
      .scan_in_i(sin),
      .adv_en_i (adv),
      .d_i      (din),
      .v_i      (vin),
      .q_o      (stg_q[k]),
      .v_o      (stg_v[k])
    );
  end

  // One token enters and/or one leaves per advance. When both happen at
  // once, the count does not change.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (adv) begin
      if (VI && !stg_v[DEPTH-1])      cnt_d = cnt_q + CW'(1);
      else if (!VI && stg_v[DEPTH-1]) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Q   = stg_q[DEPTH-1];
  assign VO  = stg_v[DEPTH-1];
  assign SO  = stg_q[DEPTH-1][WIDTH-1];
  assign CNT = cnt_q;

endmodule

// File: tb/tb_fflopd_pipe.sv
module tb_fflopd_pipe;

  logic       CK = 1'b0;
  logic       RN, EN, CLR, SE, SI, VI;
  logic [3:0] D;
  logic [3:0] Q, qa;
  logic       VO, voa, SO, soa;
  logic [1:0] CNT, cnta;

  logic [2:0] mvld;   // expected valid bits, stage2..stage0
  int nchk = 0;
  int nerr = 0;

  always #5 CK = ~CK;

  fflopd_pipe #(.WIDTH(4), .DEPTH(3), .RESET_VAL(4'h0)) dut (
    .CK(CK), .RN(RN), .EN(EN), .CLR(CLR), .SE(SE), .SI(SI), .D(D), .VI(VI),
    .Q(Q), .VO(VO), .SO(SO), .CNT(CNT)
  );

  fflopd_pipe #(.WIDTH(4), .DEPTH(3), .RESET_VAL(4'hA)) dut_a (
    .CK(CK), .RN(RN), .EN(EN), .CLR(CLR), .SE(SE), .SI(SI), .D(D), .VI(VI),
    .Q(qa), .VO(voa), .SO(soa), .CNT(cnta)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Apply one rising edge. Inputs are already stable here. Then check that
  // the occupancy counter equals the number of valid stages.
  task automatic tick();
    if (!RN || CLR)    mvld = 3'b000;
    else if (!SE && EN) mvld = {mvld[1:0], VI};
    @(posedge CK);
    #1;
    chk("cnt_pop", {30'd0, CNT}, $countones(mvld));
  endtask

  initial begin
    RN = 1'b0; EN = 1'b1; CLR = 1'b0; SE = 1'b0; SI = 1'b0;
    D = 4'hF; VI = 1'b1; mvld = '0;

    // reset holds while inputs are active
    repeat (3) tick();
    chk("rst_q",   Q,   4'h0);
    chk("rst_vo",  VO,  1'b0);
    chk("rst_cnt", CNT, 2'd0);
    chk("rst_so",  SO,  1'b0);
    chk("rst_qa",  qa,  4'hA);

    // release between edges, then fill
    RN = 1'b1;
    tick();
    chk("fill1_cnt", CNT, 2'd1);
    tick(); tick();
    chk("fill_q",   Q,   4'hF);
    chk("fill_vo",  VO,  1'b1);
    chk("fill_cnt", CNT, 2'd3);

    // push A, B, C, then stall
    D = 4'hA; tick();
    D = 4'hB; tick();
    D = 4'hC; tick();
    chk("abc_q",   Q,   4'hA);
    chk("abc_cnt", CNT, 2'd3);
    EN = 1'b0; D = 4'h5; VI = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_q",   Q,   4'hA);
      chk("stall_cnt", CNT, 2'd3);
    end

    // drain
    EN = 1'b1; D = 4'h0; VI = 1'b0;
    tick();
    chk("drain1_q",   Q,   4'hB);
    chk("drain1_cnt", CNT, 2'd2);
    tick();
    chk("drain2_q",   Q,   4'hC);
    chk("drain2_cnt", CNT, 2'd1);
    tick();
    chk("drain3_q",   Q,   4'h0);
    chk("drain3_vo",  VO,  1'b0);
    chk("drain3_cnt", CNT, 2'd0);

    // simultaneous entry and exit
    VI = 1'b1;
    D = 4'h1; tick();
    D = 4'h2; tick();
    D = 4'h3; tick();
    chk("sim_fill_q", Q, 4'h1);
    for (int i = 0; i < 5; i++) begin
      D = 4'(4 + i);
      tick();
      chk("sim_cnt", CNT, 2'd3);
      chk("sim_vo",  VO,  1'b1);
      chk("sim_q",   Q,   4'(2 + i));
    end
    // stages now hold 8, 7, 6 (stage0..stage2)

    // scan with EN high and changing D, all ignored
    SE = 1'b1; EN = 1'b1; VI = 1'b0; D = 4'hF; SI = 1'b1;
    tick();
    chk("scan1_q",   Q,   4'hC);   // 0110 << 1 | stage1[3]=0
    chk("scan1_cnt", CNT, 2'd3);
    SI = 1'b0;
    repeat (11) tick();
    chk("scan12_q",   Q,   4'h8);
    chk("scan12_so",  SO,  1'b1);
    chk("scan12_vo",  VO,  1'b1);
    chk("scan12_cnt", CNT, 2'd3);
    repeat (4) tick();
    chk("scan_stg1_zero", Q, 4'h0);
    repeat (4) tick();
    chk("scan_stg0_zero", Q, 4'h0);

    // clear beats scan and advance
    CLR = 1'b1; SE = 1'b1; EN = 1'b1; VI = 1'b1; D = 4'hF;
    tick();
    chk("clr_q",    Q,    4'h0);
    chk("clr_vo",   VO,   1'b0);
    chk("clr_cnt",  CNT,  2'd0);
    chk("clr_qa",   qa,   4'hA);
    chk("clr_voa",  voa,  1'b0);
    chk("clr_cnta", cnta, 2'd0);
    chk("clr_soa",  soa,  1'b1);
    CLR = 1'b0; SE = 1'b0;

    // async reset mid-operation
    VI = 1'b1; D = 4'h3; tick();
    D = 4'h5; tick();
    VI = 1'b0; D = 4'h0; tick();
    chk("pre_rst_q",   Q,   4'h3);
    chk("pre_rst_cnt", CNT, 2'd2);
    RN = 1'b0;
    #2;
    mvld = '0;
    chk("arst_q",   Q,   4'h0);
    chk("arst_vo",  VO,  1'b0);
    chk("arst_cnt", CNT, 2'd0);
    RN = 1'b1;
    VI = 1'b1; D = 4'h9;
    tick();
    chk("resume_cnt", CNT, 2'd1);
    VI = 1'b0; D = 4'h0;
    tick(); tick();
    chk("resume_q",   Q,   4'h9);
    chk("resume_vo",  VO,  1'b1);
    chk("resume_cnt", CNT, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
